// File: rtl/btn_press_ctrl.sv
// Four-button press classifier: SHORT / LONG / REPEAT events per button,
// queued per button and handed to a single valid/ready command port round-robin.
module btn_press_ctrl #(
    parameter int TICK_DIV  = 100_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_btn_lvl,
    input  logic       i_cmd_ready,
    output logic       o_cmd_valid,
    output logic [1:0] o_cmd_btn,
    output logic [1:0] o_cmd_type,
    output logic       o_overrun
);

    localparam int NB       = 4;
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
    localparam int HW       = $clog2(HOLD_MAX + 1);

    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_MS - 1);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESSED,
        ST_HELD
    } btn_state_e;

    typedef enum logic [1:0] {
        CMD_SHORT  = 2'b00,
        CMD_LONG   = 2'b01,
        CMD_REPEAT = 2'b10
    } cmd_type_e;

    // ------------------------------------------------------------------
    // 1 ms tick
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    // NOTE: sequential state is always updated with <= so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [NB-1:0] prev_lvl;
    logic [NB-1:0] press_evt;
    logic [NB-1:0] rel_evt;

    assign press_evt = i_btn_lvl & ~prev_lvl;
    assign rel_evt   = ~i_btn_lvl & prev_lvl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_lvl <= '0;
        end else begin
            prev_lvl <= i_btn_lvl;
        end
    end

    // ------------------------------------------------------------------
    // Per-button press classifier
    // ------------------------------------------------------------------
    btn_state_e    state_q  [NB];
    logic [HW-1:0] hold_cnt [NB];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) begin
                state_q[b]  <= ST_IDLE;
                hold_cnt[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                case (state_q[b])
                    ST_IDLE: begin
                        if (press_evt[b]) begin
                            state_q[b]  <= ST_PRESSED;
                            hold_cnt[b] <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        // A release always beats a coinciding terminal tick.
                        if (rel_evt[b]) begin
                            state_q[b] <= ST_IDLE;
                        end else if (tick) begin
                            if (hold_cnt[b] == LONG_LAST) begin
                                state_q[b]  <= ST_HELD;
                                hold_cnt[b] <= '0;
                            end else begin
                                hold_cnt[b] <= hold_cnt[b] + 1'b1;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (rel_evt[b]) begin
                            state_q[b] <= ST_IDLE;
                        end else if (tick) begin
                            if (hold_cnt[b] == REPEAT_LAST) begin
                                hold_cnt[b] <= '0;
                            end else begin
                                hold_cnt[b] <= hold_cnt[b] + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state_q[b] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Event decode mirrors the transitions above.
    logic [NB-1:0] ev_raise;
    cmd_type_e     ev_type [NB];

    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ev_raise = '0;
        for (int b = 0; b < NB; b++) begin
            ev_type[b] = CMD_SHORT;
            case (state_q[b])
                ST_PRESSED: begin
                    if (rel_evt[b]) begin
                        ev_raise[b] = 1'b1;
                        ev_type[b]  = CMD_SHORT;
                    end else if (tick && (hold_cnt[b] == LONG_LAST)) begin
                        ev_raise[b] = 1'b1;
                        ev_type[b]  = CMD_LONG;
                    end
                end
                ST_HELD: begin
                    if (!rel_evt[b] && tick && (hold_cnt[b] == REPEAT_LAST)) begin
                        ev_raise[b] = 1'b1;
                        ev_type[b]  = CMD_REPEAT;
                    end
                end
                default: begin
                    ev_raise[b] = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Round-robin grant into the output register
    // ------------------------------------------------------------------
    logic [NB-1:0] pend_q;
    cmd_type_e     pend_type_q [NB];
    logic [1:0]    last_grant;
    logic          out_free;
    logic          grant_any;
    logic [1:0]    grant_idx;
    logic [1:0]    rr_cand;
    logic [NB-1:0] grant_oh;

    always_comb begin
        out_free  = ~o_cmd_valid | i_cmd_ready;
        grant_any = 1'b0;
        grant_idx = '0;
        rr_cand   = '0;
        for (int k = 1; k <= NB; k++) begin
            rr_cand = last_grant + 2'(k);
            if (out_free && !grant_any && pend_q[rr_cand]) begin
                grant_any = 1'b1;
                grant_idx = rr_cand;
            end
        end
    end

    assign grant_oh = grant_any ? (4'b0001 << grant_idx) : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the pending-type array is only four small registers, so it is
            // reset along with everything else rather than left undefined.
            for (int b = 0; b < NB; b++) begin
                pend_type_q[b] <= CMD_SHORT;
            end
            pend_q      <= '0;
            last_grant  <= 2'd3;
            o_cmd_valid <= 1'b0;
            o_cmd_btn   <= '0;
            o_cmd_type  <= '0;
            o_overrun   <= 1'b0;
        end else begin
            // A new event outranks a same-cycle grant, so it survives the clear.
            for (int b = 0; b < NB; b++) begin
                if (ev_raise[b]) begin
                    pend_q[b]      <= 1'b1;
                    pend_type_q[b] <= ev_type[b];
                end else if (grant_oh[b]) begin
                    pend_q[b] <= 1'b0;
                end
            end

            if (|(ev_raise & pend_q & ~grant_oh)) begin
                o_overrun <= 1'b1;
            end

            if (grant_any) begin
                o_cmd_valid <= 1'b1;
                o_cmd_btn   <= grant_idx;
                o_cmd_type  <= pend_type_q[grant_idx];
                last_grant  <= grant_idx;
            end else if (out_free) begin
                o_cmd_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_btn_press_ctrl.sv
// Self-checking bench for btn_press_ctrl with TICK_DIV=4, LONG_MS=3, REPEAT_MS=2.
// Cycle numbers count clock edges since reset release; ticks fall on cycles 3, 7, 11, ...
module tb_btn_press_ctrl;

    localparam int T_SHORT  = 0;
    localparam int T_LONG   = 1;
    localparam int T_REPEAT = 2;
    localparam int NV       = 7;

    typedef struct packed {
        logic [7:0] cyc;
        logic [1:0] btn;
        logic [1:0] typ;
    } exp_cmd_t;

    typedef struct packed {
        logic [3:0]          lvl;
        logic [7:0]          hold;
        logic [2:0]          n_exp;
        exp_cmd_t [0:3]      exp;
    } vec_t;

    logic       clk;
    logic       reset;
    logic [3:0] i_btn_lvl;
    logic       i_cmd_ready;
    logic       o_cmd_valid;
    logic [1:0] o_cmd_btn;
    logic [1:0] o_cmd_type;
    logic       o_overrun;

    int         n_checks;
    int         n_fail;
    int         cyc;
    exp_cmd_t   sb [$];
    vec_t       vecs [NV];

    btn_press_ctrl #(
        .TICK_DIV (4),
        .LONG_MS  (3),
        .REPEAT_MS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_btn_lvl  (i_btn_lvl),
        .i_cmd_ready(i_cmd_ready),
        .o_cmd_valid(o_cmd_valid),
        .o_cmd_btn  (o_cmd_btn),
        .o_cmd_type (o_cmd_type),
        .o_overrun  (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    function automatic exp_cmd_t ec(input int c, input int b, input int t);
        exp_cmd_t e;
        e.cyc = 8'(c);
        e.btn = 2'(b);
        e.typ = 2'(t);
        return e;
    endfunction

    function automatic vec_t mk_vec(input logic [3:0] lvl, input int hold, input int n,
                                    input exp_cmd_t e0, input exp_cmd_t e1,
                                    input exp_cmd_t e2, input exp_cmd_t e3);
        vec_t v;
        v.lvl    = lvl;
        v.hold   = 8'(hold);
        v.n_exp  = 3'(n);
        v.exp[0] = e0;
        v.exp[1] = e1;
        v.exp[2] = e2;
        v.exp[3] = e3;
        return v;
    endfunction

    // Scoreboard: every accepted command must match the head of the queue, cycle included.
    always @(negedge clk) begin
        #1;
        if (!reset && o_cmd_valid && i_cmd_ready) begin
            check("cmd_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                exp_cmd_t e;
                e = sb.pop_front();
                check("cmd_cycle", cyc, int'(e.cyc));
                check("cmd_btn", int'(o_cmd_btn), int'(e.btn));
                check("cmd_type", int'(o_cmd_type), int'(e.typ));
            end
        end
    end

    // Leaves the caller at the negedge of cycle 0 with reset released.
    task automatic apply_reset(input logic ready);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        i_cmd_ready = ready;
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_cmd_t none;
        none = '0;
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        i_btn_lvl = '0;
        i_cmd_ready = 1'b1;

        // {levels, cycles held, commands, expected commands}
        vecs[0] = mk_vec(4'b0001, 5, 1, ec(7, 0, T_SHORT), none, none, none);
        vecs[1] = mk_vec(4'b0100, 30, 3, ec(13, 2, T_LONG), ec(21, 2, T_REPEAT),
                         ec(29, 2, T_REPEAT), none);
        vecs[2] = mk_vec(4'b1000, 11, 1, ec(13, 3, T_SHORT), none, none, none);
        vecs[3] = mk_vec(4'b0001, 10, 1, ec(12, 0, T_SHORT), none, none, none);
        vecs[4] = mk_vec(4'b0001, 12, 1, ec(13, 0, T_LONG), none, none, none);
        vecs[5] = mk_vec(4'b0010, 19, 1, ec(13, 1, T_LONG), none, none, none);
        vecs[6] = mk_vec(4'b0010, 20, 2, ec(13, 1, T_LONG), ec(21, 1, T_REPEAT), none, none);

        step(3);
        #1;
        check("rst_valid", int'(o_cmd_valid), 0);
        check("rst_btn", int'(o_cmd_btn), 0);
        check("rst_type", int'(o_cmd_type), 0);
        check("rst_overrun", int'(o_overrun), 0);

        for (int v = 0; v < NV; v++) begin
            apply_reset(1'b1);
            i_btn_lvl = vecs[v].lvl;
            for (int k = 0; k < int'(vecs[v].n_exp); k++) sb.push_back(vecs[v].exp[k]);
            step(int'(vecs[v].hold));
            i_btn_lvl = '0;
            step(16);
            #2;
            check($sformatf("vec%0d_drained", v), sb.size(), 0);
        end

        // Round robin resumes after the last grant: btn0 then {btn0,btn2} -> btn2 first.
        apply_reset(1'b1);
        i_btn_lvl = 4'b0001;
        sb.push_back(ec(4, 0, T_SHORT));
        step(2);
        i_btn_lvl = '0;
        step(6);
        i_btn_lvl = 4'b0101;
        sb.push_back(ec(12, 2, T_SHORT));
        sb.push_back(ec(13, 0, T_SHORT));
        step(2);
        i_btn_lvl = '0;
        step(10);
        #2;
        check("rr_drained", sb.size(), 0);

        // Four simultaneous SHORTs, twice; each burst starts at btn0.
        apply_reset(1'b1);
        i_btn_lvl = 4'b1111;
        for (int b = 0; b < 4; b++) sb.push_back(ec(7 + b, b, T_SHORT));
        step(5);
        i_btn_lvl = '0;
        step(7);
        i_btn_lvl = 4'b1111;
        for (int b = 0; b < 4; b++) sb.push_back(ec(19 + b, b, T_SHORT));
        step(5);
        i_btn_lvl = '0;
        step(12);
        #2;
        check("burst_drained", sb.size(), 0);

        // Back-pressure: output holds, second SHORT waits, third sets overrun.
        apply_reset(1'b0);
        i_btn_lvl = 4'b0010;
        step(2);
        i_btn_lvl = '0;
        step(2);
        for (int c = 4; c < 14; c++) begin
            i_btn_lvl = (c == 4 || c == 5 || c == 8 || c == 9) ? 4'b0010 : 4'b0000;
            #1;
            check("hold_valid", int'(o_cmd_valid), 1);
            check("hold_btn", int'(o_cmd_btn), 1);
            check("hold_type", int'(o_cmd_type), T_SHORT);
            if (c == 9)  check("overrun_before", int'(o_overrun), 0);
            if (c == 11) check("overrun_after", int'(o_overrun), 1);
            @(negedge clk);
        end
        sb.push_back(ec(14, 1, T_SHORT));
        sb.push_back(ec(15, 1, T_SHORT));
        i_cmd_ready = 1'b1;
        step(2);
        #2;
        check("bp_valid_drop", int'(o_cmd_valid), 0);
        step(6);
        #2;
        check("bp_drained", sb.size(), 0);
        check("overrun_sticky", int'(o_overrun), 1);

        // Reset mid-flight with btn1 in the output, btn0/btn2 pending and btn3 held.
        apply_reset(1'b0);
        i_btn_lvl = 4'b1110;
        step(2);
        i_btn_lvl = 4'b1000;
        step(2);
        i_btn_lvl = 4'b1001;
        step(2);
        i_btn_lvl = 4'b1000;
        step(2);
        #1;
        check("pre_rst_valid", int'(o_cmd_valid), 1);
        check("pre_rst_btn", int'(o_cmd_btn), 1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", int'(o_cmd_valid), 0);
        check("mid_rst_btn", int'(o_cmd_btn), 0);
        check("mid_rst_type", int'(o_cmd_type), 0);
        step(2);
        i_cmd_ready = 1'b1;
        reset = 1'b0;
        sb.push_back(ec(5, 3, T_SHORT));
        step(3);
        i_btn_lvl = '0;
        step(12);
        #2;
        check("post_rst_drained", sb.size(), 0);
        check("post_rst_overrun", int'(o_overrun), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
